// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one byte at a time and serializes each byte as an 8N1 UART frame, LSB first.
// state | meaning: IDLE wait for enable & data, FETCH read strobe, WAIT data capture, START/DATA/STOP frame bits
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    output logic        tx,
    output logic        busy,
    output logic        byte_done,
    output logic [15:0] bytes_sent
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shreg;
    logic            r_tx;
    logic            r_rd_en;
    logic            r_busy;
    logic            r_done;
    logic [15:0]     r_bytes_sent;
    logic            w_bit_end;

    assign w_bit_end  = (r_cnt == LAST_CNT);
    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign byte_done  = r_done;
    assign bytes_sent = r_bytes_sent;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shreg      <= '0;
            r_tx         <= 1'b1;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bytes_sent <= '0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        r_state <= S_FETCH;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                // Read data is valid in this cycle, one cycle after the strobe.
                S_WAIT: begin
                    r_shreg <= fifo_rd_data;
                    r_tx    <= 1'b0;
                    r_state <= S_START;
                    r_cnt   <= '0;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shreg[0];
                        r_bit   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shreg <= r_shreg >> 1;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx <= r_shreg[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_state      <= S_IDLE;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_bytes_sent <= r_bytes_sent + 16'd1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-based FIFO model, frame decoder on tx and a byte scoreboard.
module tb_fifo_uart_tx;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic        byte_done;
    logic [15:0] bytes_sent;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    int          starts[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rd_count = 0;
    int          bd_count = 0;
    int          frames_done = 0;
    int          last_fetch = 0;
    logic        prev_rd = 1'b0;
    logic [15:0] exp_sent = 16'd0;

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .tx           (tx),
        .busy         (busy),
        .byte_done    (byte_done),
        .bytes_sent   (bytes_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // FIFO model: a strobe pops the head, data is presented for the following cycle.
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            if (prev_rd) begin
                chk("rd_en_width", {31'd0, prev_rd}, 32'd0);
            end else begin
                rd_count++;
                chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
                last_fetch = cyc;
                if (fifo_q.size() > 0) begin
                    fifo_rd_data = fifo_q.pop_front();
                    exp_q.push_back(fifo_rd_data);
                end
            end
        end
        prev_rd = fifo_rd_en;
        fifo_empty = (fifo_q.size() == 0);
        if (byte_done) bd_count++;
    end

    // Monitor: decode every frame seen on tx and check it against the scoreboard.
    initial begin : monitor
        logic [10*N-1:0] samp;
        logic [9:0]      bits;
        logic            aborted;
        logic            busy_ok;
        logic            quiet_ok;
        logic            stable;
        int              start_cyc;
        forever begin
            @(negedge clk);
            if (reset || tx !== 1'b0) continue;
            start_cyc = cyc;
            chk("fetch_to_start", start_cyc - last_fetch, 32'd2);
            aborted  = 1'b0;
            busy_ok  = 1'b1;
            quiet_ok = 1'b1;
            for (int i = 0; i < 10*N; i++) begin
                if (i > 0) @(negedge clk);
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
                samp[i] = tx;
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (byte_done !== 1'b0 || fifo_rd_en !== 1'b0) quiet_ok = 1'b0;
            end
            if (aborted) begin
                @(negedge clk);
                chk("reset_tx", {31'd0, tx}, 32'd1);
                chk("reset_busy", {31'd0, busy}, 32'd0);
                chk("reset_byte_done", {31'd0, byte_done}, 32'd0);
                chk("reset_bytes_sent", {16'd0, bytes_sent}, 32'd0);
                continue;
            end
            chk("busy_in_frame", {31'd0, busy_ok}, 32'd1);
            chk("quiet_in_frame", {31'd0, quiet_ok}, 32'd1);
            @(negedge clk);
            chk("byte_done_pulse", {31'd0, byte_done}, 32'd1);
            chk("busy_after", {31'd0, busy}, 32'd0);
            stable = 1'b1;
            for (int b = 0; b < 10; b++) begin
                bits[b] = samp[b*N];
                for (int c = 1; c < N; c++) begin
                    if (samp[b*N+c] !== bits[b]) stable = 1'b0;
                end
            end
            chk("bit_stable", {31'd0, stable}, 32'd1);
            chk("start_bit", {31'd0, bits[0]}, 32'd0);
            chk("stop_bit", {31'd0, bits[9]}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", exp_q.size(), 32'd1);
            end else begin
                chk("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
            end
            exp_sent = exp_sent + 16'd1;
            chk("bytes_sent", {16'd0, bytes_sent}, {16'd0, exp_sent});
            starts.push_back(start_cyc);
            frames_done++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_sent = 16'd0;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (frames_done < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("frames_done", frames_done, target);
    endtask

    task automatic wait_tx_low(input int budget);
        int c = 0;
        @(negedge clk);
        while (tx !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("tx_start_seen", {31'd0, tx}, 32'd0);
        cycles(1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bd_saved;
        int fd_saved;
        int c;

        do_reset();
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_byte_done", {31'd0, byte_done}, 32'd0);
        chk("rst_bytes_sent", {16'd0, bytes_sent}, 32'd0);
        cycles(1);

        // Empty FIFO with enable held: nothing may happen.
        enable = 1'b1;
        cycles(100);
        @(negedge clk);
        chk("empty_rd_count", rd_count, 32'd0);
        chk("empty_tx", {31'd0, tx}, 32'd1);
        chk("empty_busy", {31'd0, busy}, 32'd0);
        chk("empty_bytes_sent", {16'd0, bytes_sent}, 32'd0);
        cycles(1);

        // Single byte 0xA5.
        fifo_q.push_back(8'hA5);
        wait_frames(1, 100);
        chk("single_rd_count", rd_count, 32'd1);

        // Three preloaded bytes back to back, including 0x00.
        enable = 1'b0;
        starts.delete();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h3C);
        cycles(2);
        enable = 1'b1;
        wait_frames(4, 200);
        chk("b2b_frames", starts.size(), 32'd3);
        if (starts.size() == 3) begin
            chk("b2b_period0", starts[1] - starts[0], 10*N + 3);
            chk("b2b_period1", starts[2] - starts[1], 10*N + 3);
        end
        chk("b2b_rd_count", rd_count, 32'd4);

        // Enable drops mid-frame: first frame completes, second not fetched.
        enable = 1'b0;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        cycles(2);
        enable = 1'b1;
        wait_tx_low(20);
        cycles(3*N);
        enable = 1'b0;
        wait_frames(5, 80);
        cycles(30);
        chk("drop_rd_count", rd_count, 32'd5);
        chk("drop_fifo_left", fifo_q.size(), 32'd1);
        enable = 1'b1;
        wait_frames(6, 80);

        // Reset during data bit 3.
        fifo_q.push_back(8'h96);
        wait_tx_low(20);
        cycles(4*N + N/2);
        bd_saved = bd_count;
        fd_saved = frames_done;
        do_reset();
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_bytes_sent", {16'd0, bytes_sent}, 32'd0);
        chk("midrst_no_done", bd_count, bd_saved);
        chk("midrst_frames", frames_done, fd_saved);
        cycles(1);
        fifo_q.push_back(8'h5A);
        wait_frames(fd_saved + 1, 80);

        // bytes_sent wrap from 0xFFFF.
        enable = 1'b0;
        cycles(2);
        @(negedge clk);
        force dut.r_bytes_sent = 16'hFFFF;
        @(negedge clk);
        release dut.r_bytes_sent;
        exp_sent = 16'hFFFF;
        @(negedge clk);
        chk("preset_bytes_sent", {16'd0, bytes_sent}, 32'h0000FFFF);
        cycles(1);
        fifo_q.push_back(8'hC3);
        enable = 1'b1;
        wait_frames(fd_saved + 2, 80);
        @(negedge clk);
        chk("wrap_bytes_sent", {16'd0, bytes_sent}, 32'd0);
        cycles(1);

        // Random bytes and random enable toggling.
        for (int it = 0; it < 25; it++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) fifo_q.push_back(8'($urandom_range(0, 255)));
            enable = ($urandom_range(0, 3) != 0);
            cycles($urandom_range(1, 60));
        end
        enable = 1'b1;
        c = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && c < 6000) begin
            @(posedge clk);
            c++;
        end
        cycles(5);
        chk("drain_left", fifo_q.size() + exp_q.size(), 32'd0);
        chk("done_vs_frames", bd_count, frames_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain-side consumer for the team's 8-bit byte FIFO. When enabled, it pulls one byte at a time through the FIFO read port and serializes each byte as a standard UART frame: 8N1, LSB first. It sits between the FIFO's read side and the board TX pin, and it never issues a read while the FIFO reports empty.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clk cycles per UART bit; legal values are 2 or more.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  permits new FIFO fetches; sampled only in IDLE.
- fifo_empty  input  1  FIFO has no data; sampled only in IDLE.
- fifo_rd_en  output  1  registered read strobe to the FIFO; exactly one cycle high per byte.
- fifo_rd_data  input  8  FIFO read data; valid in the cycle after the cycle in which fifo_rd_en is high.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  high in every state except IDLE.
- byte_done  output  1  one-cycle pulse when a stop bit completes.
- bytes_sent  output  16  count of completed frames; wraps modulo 2^16.

## Operation
- States: IDLE, FETCH, WAIT, START, DATA, STOP.
- IDLE:
  - If enable=1 and fifo_empty=0, go to FETCH and register fifo_rd_en=1.
  - Otherwise stay in IDLE with tx=1.
- FETCH (1 cycle): fifo_rd_en=1. Next state is WAIT, with fifo_rd_en cleared to 0.
- WAIT (1 cycle):
  - At the end of this cycle, capture fifo_rd_data into an 8-bit shift register.
  - Go to START and register tx=0.
  - fifo_empty and enable are ignored here.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shreg[0].
- DATA:
  - Each bit lasts CLKS_PER_BIT cycles.
  - At each bit boundary, shift right and increment a 3-bit bit index.
  - After bit 7, go to STOP with tx=1.
- STOP:
  - Hold tx=1 for CLKS_PER_BIT cycles.
  - On exit, pulse byte_done, increment bytes_sent and return to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads to 0 on every state entry, width $clog2(CLKS_PER_BIT).
- Byte value 0x00 is ordinary data and is transmitted normally. Emptiness comes only from fifo_empty.
- enable falling mid-frame: the current frame completes in full; no further fetch is issued.
- fifo_empty rising during FETCH or WAIT: the fetched byte is still transmitted.
- Reset at any point, including mid-frame:
  - Next edge: state=IDLE, tx=1, fifo_rd_en=0, busy=0, byte_done=0, bytes_sent=0, shift register=0, counters=0.
  - A partial frame is abandoned and is not counted.

## Timing
- Reset values: tx=1, fifo_rd_en=0, busy=0, byte_done=0, bytes_sent=0.
- Label edges from the edge at which IDLE sees enable & !fifo_empty, called edge k. Then:
  - fifo_rd_en is high between edges k and k+1.
  - tx falls at edge k+2.
  - data bit i starts at edge k+2+(1+i)*CLKS_PER_BIT.
  - the stop bit starts at edge k+2+9*CLKS_PER_BIT.
  - IDLE is re-entered, byte_done pulses and bytes_sent increments at edge k+2+10*CLKS_PER_BIT.
- Frame length on tx: exactly 10*CLKS_PER_BIT cycles.
- Back-to-back bytes: start-bit-to-start-bit period is 10*CLKS_PER_BIT+3 cycles (IDLE, FETCH and WAIT take one cycle each).
- busy rises at edge k and falls at the same edge as byte_done.

## Test plan
- Reset, then hold fifo_empty=1 and enable=1 for 100 cycles -> tx=1, fifo_rd_en never asserts, busy=0, bytes_sent=0.
- CLKS_PER_BIT=4, single byte 0xA5 -> fifo_rd_en is one cycle; tx pattern at 4 cycles/bit is 0,1,0,1,0,0,1,0,1,1; byte_done pulses once, 40 cycles after the start bit; bytes_sent=1.
- Model FIFO preloaded with 0x00, 0xFF, 0x3C, enable held high -> three frames each 43 cycles apart; the 0x00 frame is sent with all data bits 0; fifo_rd_en pulses exactly 3 times and never while fifo_empty=1; bytes_sent=3.
- Drop enable during DATA of the first of two queued bytes -> the first frame completes intact and the second is not fetched; re-raise enable -> the second byte is sent.
- Assert reset during bit 3 of a frame -> tx=1 on the next edge; bytes_sent=0; no byte_done pulse; the next fetch starts cleanly after reset is released.
- Preset bytes_sent to 0xFFFF via 65535 frames (or a forced value), then send one byte -> bytes_sent=0x0000 and byte_done pulses.
